ucode_mcr_ctrl: RTL and testbench

- Memory-controller responder for the microcode fetch/write interface used when the on-chip 16Kx49 control-store RAM is not built in.
- Accepts fetch, prefetch and write requests from the CPU side, each carrying a 14-bit microcode address.
- Services them against an external 32-bit word memory through a req/ack handshake. Each 49-bit microinstruction occupies two consecutive 32-bit words.
- Holds a one-entry prefetch buffer, so a fetch that follows a matching prefetch completes without a memory access.

---
 rtl/ucode_mcr_ctrl_if.sv | 35 +++
 rtl/ucode_mcr_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ucode_mcr_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucode_mcr_ctrl_if.sv
// ucode_mcr_ctrl_if
//   Bundles the CPU-side microcode request bus and the external 32-bit word
//   memory bus of the microcode memory-controller responder.
//   slave  : view taken by ucode_mcr_ctrl (takes CPU requests, masters memory).
//   master : view taken by the environment (CPU request source + word memory).
//   CPU side : mcr_addr[13:0], mcr_wdata[48:0], mcr_write, fetch, prefetch
//              -> mcr_rdata[48:0], mcr_ready, mcr_busy
//   Mem side : mem_addr[14:0], mem_wdata[31:0], mem_we, mem_req
//              <- mem_rdata[31:0], mem_ack
interface ucode_mcr_ctrl_if;
  logic [13:0] mcr_addr;
  logic [48:0] mcr_wdata;
  logic        mcr_write;
  logic        fetch;
  logic        prefetch;
  logic [48:0] mcr_rdata;
  logic        mcr_ready;
  logic        mcr_busy;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  mcr_addr, mcr_wdata, mcr_write, fetch, prefetch, mem_rdata, mem_ack,
    output mcr_rdata, mcr_ready, mcr_busy, mem_addr, mem_wdata, mem_we, mem_req
  );

  modport master (
    output mcr_addr, mcr_wdata, mcr_write, fetch, prefetch, mem_rdata, mem_ack,
    input  mcr_rdata, mcr_ready, mcr_busy, mem_addr, mem_wdata, mem_we, mem_req
  );
endinterface

// File: rtl/ucode_mcr_ctrl.sv
// ucode_mcr_ctrl
//   Microcode fetch/write responder used when the 16Kx49 control store is
//   external. Each 49-bit microinstruction lives in two 32-bit memory words
//   ({addr,0} = bits 31:0, {addr,1} = bits 48:32 in word bits 16:0).
//   A one-entry prefetch buffer lets a fetch following a matching prefetch
//   complete in one cycle without touching memory.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : ucode_mcr_ctrl_if.slave (CPU request bus + external memory bus)
// Parameters:
//   PREFETCH_EN : 1 enables the prefetch buffer; 0 ignores prefetch hints
//   HI_PAD      : fill bit replicated into mem_wdata[31:17] on high-half writes
module ucode_mcr_ctrl #(
  parameter logic PREFETCH_EN = 1'b1,
  parameter logic HI_PAD      = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  ucode_mcr_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] WR_LO = 3'd3;
  localparam logic [2:0] WR_HI = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [48:0] wdata_q, wdata_d;
  logic        is_pf_q, is_pf_d;
  logic [48:0] mcr_rdata_q, mcr_rdata_d;
  logic        mcr_ready_q, mcr_ready_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        buf_valid_q, buf_valid_d;
  logic [13:0] buf_tag_q, buf_tag_d;
  logic [48:0] buf_data_q, buf_data_d;

  logic        tag_hit;

  assign tag_hit = buf_valid_q && (buf_tag_q == bus.mcr_addr);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_pf_d     = is_pf_q;
    mcr_rdata_d = mcr_rdata_q;
    mcr_ready_d = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;

    case (state_q)
      IDLE: begin
        if (bus.mcr_write) begin
          addr_d      = bus.mcr_addr;
          wdata_d     = bus.mcr_wdata;
          is_pf_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {bus.mcr_addr, 1'b0};
          mem_wdata_d = bus.mcr_wdata[31:0];
          state_d     = WR_LO;
        end else if (bus.fetch) begin
          addr_d  = bus.mcr_addr;
          is_pf_d = 1'b0;
          if (tag_hit) begin
            mcr_rdata_d = buf_data_q;
            mcr_ready_d = 1'b1;
            state_d     = RESP;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {bus.mcr_addr, 1'b0};
            state_d    = RD_LO;
          end
        end else if (PREFETCH_EN && bus.prefetch && !tag_hit) begin
          addr_d     = bus.mcr_addr;
          is_pf_d    = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {bus.mcr_addr, 1'b0};
          state_d    = RD_LO;
        end
      end

      RD_LO: begin
        if (bus.mem_ack) begin
          // A prefetch fills the shadow buffer instead of mcr_rdata; the
          // buffer is invalid until its high half lands.
          if (is_pf_q) begin
            buf_data_d[31:0] = bus.mem_rdata;
            buf_valid_d      = 1'b0;
          end else begin
            mcr_rdata_d[31:0] = bus.mem_rdata;
          end
          mem_addr_d = {addr_q, 1'b1};
          state_d    = RD_HI;
        end
      end

      RD_HI: begin
        if (bus.mem_ack) begin
          if (is_pf_q) begin
            buf_data_d[48:32] = bus.mem_rdata[16:0];
            buf_tag_d         = addr_q;
            buf_valid_d       = 1'b1;
          end else begin
            mcr_rdata_d[48:32] = bus.mem_rdata[16:0];
            mcr_ready_d        = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end

      WR_LO: begin
        if (bus.mem_ack) begin
          mem_addr_d  = {addr_q, 1'b1};
          mem_wdata_d = {{15{HI_PAD}}, wdata_q[48:32]};
          state_d     = WR_HI;
        end
      end

      WR_HI: begin
        if (bus.mem_ack) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mcr_ready_d = 1'b1;
          // Keep the prefetch buffer coherent with the word just written.
          if (buf_valid_q && (buf_tag_q == addr_q)) begin
            buf_data_d = wdata_q;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_pf_q     <= 1'b0;
      mcr_rdata_q <= '0;
      mcr_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_pf_q     <= is_pf_d;
      mcr_rdata_q <= mcr_rdata_d;
      mcr_ready_q <= mcr_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign bus.mcr_rdata = mcr_rdata_q;
  assign bus.mcr_ready = mcr_ready_q;
  assign bus.mcr_busy  = (state_q != IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_req   = mem_req_q;

endmodule

// File: tb/tb_ucode_mcr_ctrl.sv
// tb_ucode_mcr_ctrl
//   Drives ucode_mcr_ctrl through directed scenarios and a randomized mix of
//   fetch/write/prefetch, against a word-memory responder and a reference
//   model of the control store plus its one-entry prefetch buffer.
module tb_ucode_mcr_ctrl;
  localparam logic TB_HI_PAD = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ucode_mcr_ctrl_if bus ();

  ucode_mcr_ctrl #(.PREFETCH_EN(1'b1), .HI_PAD(TB_HI_PAD)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [31:0] data;
  } xfer_t;

  // Memory responder state
  xfer_t       log_q[$];
  logic [31:0] ext_mem [32768];
  int          ack_delay;
  int          ack_limit;
  int          acks_given;
  int          inject_req;
  int          inject_seen;
  int          resp_wait;
  logic        resp_prev;

  // Reference model
  logic [31:0] ref_mem [32768];
  logic        m_valid;
  logic [13:0] m_tag;
  logic [48:0] m_data;
  logic [48:0] m_last;

  int checks;
  int errors;

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 10) return 32'h89AB_CDEF;
    if (i == 11) return 32'h0001_FFFF;
    return (i * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [48:0] model_word(input logic [13:0] a);
    logic [31:0] hi;
    hi = ref_mem[{a, 1'b1}];
    return {hi[16:0], ref_mem[{a, 1'b0}]};
  endfunction

  function automatic logic model_hit(input logic [13:0] a);
    return m_valid && (m_tag == a);
  endfunction

  task automatic model_write(input logic [13:0] a, input logic [48:0] wd);
    ref_mem[{a, 1'b0}] = wd[31:0];
    ref_mem[{a, 1'b1}] = {{15{TB_HI_PAD}}, wd[48:32]};
    if (model_hit(a)) m_data = wd;
  endtask

  // Word-memory responder: decides ack on the falling edge so it is stable
  // at the next rising edge.
  initial begin
    for (int unsigned i = 0; i < 32768; i++) ext_mem[i] = init_word(i);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    acks_given    = 0;
    inject_seen   = 0;
    resp_wait     = 0;
    forever begin
      @(negedge clk);
      resp_prev   = bus.mem_ack;
      bus.mem_ack = 1'b0;
      if (resp_prev) resp_wait = 0;
      if (inject_seen != inject_req) begin
        inject_seen = inject_req;
        bus.mem_ack = 1'b1;
      end else if (bus.mem_req === 1'b1 && rst_n === 1'b1 &&
                   (ack_limit < 0 || acks_given < ack_limit)) begin
        if (resp_wait >= ack_delay) begin
          bus.mem_ack = 1'b1;
          resp_wait   = 0;
          acks_given++;
          if (bus.mem_we) ext_mem[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = ext_mem[bus.mem_addr];
          log_q.push_back('{we: bus.mem_we, addr: bus.mem_addr, data: bus.mem_wdata});
        end else begin
          resp_wait++;
        end
      end else begin
        resp_wait = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // kind: 0 fetch, 1 write, 2 prefetch. For fetch/write lat = cycles from
  // the sampling edge to mcr_ready; for prefetch lat = cycles busy.
  task automatic run_op(input int kind, input logic [13:0] a, input logic [48:0] wd,
                        output int lat, output int nready, output int nxfer,
                        output int base, output logic [48:0] rd, output logic addr_ok);
    int   guard;
    logic phase;
    lat = 0; nready = 0; addr_ok = 1'b1; guard = 0;
    while (bus.mcr_busy !== 1'b0 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    base          = log_q.size();
    bus.mcr_addr  = a;
    bus.mcr_wdata = wd;
    case (kind)
      0:       bus.fetch     = 1'b1;
      1:       bus.mcr_write = 1'b1;
      default: bus.prefetch  = 1'b1;
    endcase
    if (kind == 2) begin
      @(posedge clk); #1;
      bus.prefetch = 1'b0;
      guard = 0;
      while (bus.mcr_busy === 1'b1 && guard < 200) begin
        lat++;
        if (bus.mcr_ready === 1'b1) nready++;
        phase = (log_q.size() != base);
        if (bus.mem_req === 1'b1 && bus.mem_addr !== {a, phase}) addr_ok = 1'b0;
        @(posedge clk); #1; guard++;
      end
      if (guard >= 200) lat = -1;
    end else begin
      guard = 0;
      do begin
        @(posedge clk); #1;
        lat++; guard++;
        phase = (log_q.size() != base);
        if (bus.mem_req === 1'b1 && bus.mem_addr !== {a, phase}) addr_ok = 1'b0;
      end while (bus.mcr_ready !== 1'b1 && guard < 200);
      if (bus.mcr_ready !== 1'b1) lat = -1;
      else nready = 1;
      bus.fetch     = 1'b0;
      bus.mcr_write = 1'b0;
    end
    rd = bus.mcr_rdata;
    if (kind != 2) begin
      @(posedge clk); #1;
    end
    nxfer = log_q.size() - base;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.mcr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.mcr_ready); end
    checks++; if (bus.mcr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.mcr_busy); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    checks++; if (bus.mcr_rdata !== 49'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.mcr_rdata); end
    checks++; if (bus.mem_addr !== 15'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.mcr_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", bus.mcr_busy); end
    m_valid = 1'b0;
    m_last  = '0;
  endtask

  task automatic test_fetch_miss();
    int lat, nr, nx, b; logic [48:0] rd; logic ok;
    ack_delay = 0;
    run_op(0, 14'h0005, '0, lat, nr, nx, b, rd, ok);
    m_last = model_word(14'h0005);
    checks++; if (lat != 3) begin errors++; $display("FAIL miss_latency: got %0d expected 3", lat); end
    checks++; if (rd !== m_last) begin errors++; $display("FAIL miss_data: got %h expected %h", rd, m_last); end
    checks++; if (nx != 2) begin errors++; $display("FAIL miss_xfers: got %0d expected 2", nx); end
    if (nx == 2) begin
      checks++; if (log_q[b].addr !== 15'd10 || log_q[b].we !== 1'b0) begin errors++; $display("FAIL miss_lo_addr: got %0d/%b expected 10/0", log_q[b].addr, log_q[b].we); end
      checks++; if (log_q[b+1].addr !== 15'd11 || log_q[b+1].we !== 1'b0) begin errors++; $display("FAIL miss_hi_addr: got %0d/%b expected 11/0", log_q[b+1].addr, log_q[b+1].we); end
    end
    checks++; if (!ok) begin errors++; $display("FAIL miss_addr_stable: got 0 expected 1"); end
  endtask

  task automatic test_prefetch();
    int lat, nr, nx, b; logic [48:0] rd; logic ok;
    run_op(2, 14'h0100, '0, lat, nr, nx, b, rd, ok);
    m_valid = 1'b1; m_tag = 14'h0100; m_data = model_word(14'h0100);
    checks++; if (nx != 2) begin errors++; $display("FAIL pf_xfers: got %0d expected 2", nx); end
    checks++; if (nr != 0) begin errors++; $display("FAIL pf_ready: got %0d expected 0", nr); end
    checks++; if (rd !== m_last) begin errors++; $display("FAIL pf_rdata_kept: got %h expected %h", rd, m_last); end
    run_op(0, 14'h0100, '0, lat, nr, nx, b, rd, ok);
    m_last = m_data;
    checks++; if (lat != 1) begin errors++; $display("FAIL hit_latency: got %0d expected 1", lat); end
    checks++; if (nx != 0) begin errors++; $display("FAIL hit_xfers: got %0d expected 0", nx); end
    checks++; if (rd !== m_last) begin errors++; $display("FAIL hit_data: got %h expected %h", rd, m_last); end
  endtask

  task automatic test_write_coherent();
    int lat, nr, nx, b; logic [48:0] rd; logic ok;
    logic [48:0] wd;
    xfer_t exp_lo, exp_hi;
    wd = 49'h1_2345_6789_ABCD;
    exp_lo = '{we: 1'b1, addr: 15'h0200, data: 32'h6789_ABCD};
    exp_hi = '{we: 1'b1, addr: 15'h0201, data: 32'h0001_2345};
    run_op(1, 14'h0100, wd, lat, nr, nx, b, rd, ok);
    model_write(14'h0100, wd);
    checks++; if (lat != 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (nx != 2) begin errors++; $display("FAIL wr_xfers: got %0d expected 2", nx); end
    if (nx == 2) begin
      checks++; if (log_q[b] !== exp_lo) begin errors++; $display("FAIL wr_lo: got %h expected %h", log_q[b], exp_lo); end
      checks++; if (log_q[b+1] !== exp_hi) begin errors++; $display("FAIL wr_hi: got %h expected %h", log_q[b+1], exp_hi); end
    end
    run_op(0, 14'h0100, '0, lat, nr, nx, b, rd, ok);
    m_last = m_data;
    checks++; if (lat != 1 || nx != 0) begin errors++; $display("FAIL wr_then_hit: got lat %0d xfers %0d expected 1 0", lat, nx); end
    checks++; if (rd !== wd) begin errors++; $display("FAIL wr_coherent_data: got %h expected %h", rd, wd); end
  endtask

  task automatic test_priority();
    int guard, n, b, lat, nr, nx; logic [48:0] wd, rd; logic ok;
    wd = {17'($urandom), 32'($urandom)};
    guard = 0;
    while (bus.mcr_busy !== 1'b0 && guard < 100) begin @(posedge clk); #1; guard++; end
    b = log_q.size();
    bus.mcr_addr = 14'h0222; bus.mcr_wdata = wd;
    bus.fetch = 1'b1; bus.mcr_write = 1'b1; bus.prefetch = 1'b1;
    @(posedge clk); #1;
    bus.prefetch = 1'b0;
    guard = 0;
    while (bus.mcr_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    bus.mcr_write = 1'b0;
    model_write(14'h0222, wd);
    checks++; if (log_q.size() - b != 2 || log_q[b].we !== 1'b1) begin errors++; $display("FAIL prio_write_first: got %0d xfers expected 2 writes", log_q.size() - b); end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.mcr_ready !== 1'b1 && n < 50);
    bus.fetch = 1'b0;
    m_last = model_word(14'h0222);
    checks++; if (n != 4) begin errors++; $display("FAIL prio_fetch_after: got %0d cycles expected 4", n); end
    checks++; if (bus.mcr_rdata !== m_last) begin errors++; $display("FAIL prio_fetch_data: got %h expected %h", bus.mcr_rdata, m_last); end
    @(posedge clk); #1;
    checks++; if (log_q.size() - b != 4) begin errors++; $display("FAIL prio_xfer_total: got %0d expected 4", log_q.size() - b); end
    // The dropped prefetch must not have filled the buffer.
    run_op(0, 14'h0222, '0, lat, nr, nx, b, rd, ok);
    checks++; if (lat != 3 || nx != 2) begin errors++; $display("FAIL prio_pf_dropped: got lat %0d xfers %0d expected 3 2", lat, nx); end
  endtask

  task automatic test_reset_midflight();
    int lat, nr, nx, b, guard; logic [48:0] rd; logic ok, quiet, reached;
    run_op(2, 14'h0300, '0, lat, nr, nx, b, rd, ok);
    m_valid = 1'b1; m_tag = 14'h0300; m_data = model_word(14'h0300);
    checks++; if (nx != 2) begin errors++; $display("FAIL mid_pf_xfers: got %0d expected 2", nx); end
    ack_limit = acks_given + 1;
    bus.mcr_addr = 14'h0301; bus.fetch = 1'b1;
    reached = 1'b0; guard = 0;
    while (!reached && guard < 20) begin
      @(posedge clk); #1; guard++;
      if (bus.mem_req === 1'b1 && bus.mem_addr === {14'h0301, 1'b1}) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL mid_reach_rd_hi: got 0 expected 1"); end
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mid_req_async: got %b expected 0", bus.mem_req); end
    checks++; if (bus.mcr_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async: got %b expected 0", bus.mcr_busy); end
    bus.fetch = 1'b0;
    m_valid = 1'b0; m_last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    ack_limit = -1;
    inject_req++;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.mcr_busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.mcr_ready !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL late_ack_ignored: got 0 expected 1"); end
    run_op(0, 14'h0300, '0, lat, nr, nx, b, rd, ok);
    m_last = model_word(14'h0300);
    checks++; if (lat != 3 || nx != 2) begin errors++; $display("FAIL mid_buffer_invalid: got lat %0d xfers %0d expected 3 2", lat, nx); end
    checks++; if (rd !== m_last) begin errors++; $display("FAIL mid_refetch_data: got %h expected %h", rd, m_last); end
  endtask

  task automatic test_wait_wrap();
    int lat, nr, nx, b, exp_lat; logic [48:0] rd; logic ok;
    ack_delay = 4;
    exp_lat = model_hit(14'h3FFF) ? 1 : 2 * (4 + 1) + 1;
    run_op(0, 14'h3FFF, '0, lat, nr, nx, b, rd, ok);
    m_last = model_hit(14'h3FFF) ? m_data : model_word(14'h3FFF);
    ack_delay = 0;
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL wait_latency: got %0d expected %0d", lat, exp_lat); end
    checks++; if (!ok) begin errors++; $display("FAIL wait_addr_stable: got 0 expected 1"); end
    checks++; if (rd !== m_last) begin errors++; $display("FAIL wait_data: got %h expected %h", rd, m_last); end
    if (nx == 2) begin
      checks++; if (log_q[b].addr !== 15'h7FFE || log_q[b+1].addr !== 15'h7FFF) begin errors++; $display("FAIL wrap_addr: got %h %h expected 7ffe 7fff", log_q[b].addr, log_q[b+1].addr); end
    end else begin
      checks++; errors++; $display("FAIL wait_xfers: got %0d expected 2", nx);
    end
  endtask

  task automatic test_random();
    int lat, nr, nx, b, kind, d, exp_lat, exp_nx;
    logic [48:0] rd, wd; logic ok, hit; logic [13:0] a;
    xfer_t exp_lo, exp_hi;
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       a = 14'h0010;
        1:       a = 14'h0011;
        2:       a = 14'h3FFF;
        default: a = 14'($urandom_range(0, 16383));
      endcase
      wd = {17'($urandom), 32'($urandom)};
      d  = int'($urandom_range(0, 2));
      ack_delay = d;
      hit = model_hit(a);
      exp_lat = 2 * (d + 1) + 1;
      exp_nx  = 2;
      if (kind == 0 && hit) begin exp_lat = 1; exp_nx = 0; end
      if (kind == 2 && hit) begin exp_lat = 0; exp_nx = 0; end
      run_op(kind, a, wd, lat, nr, nx, b, rd, ok);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency kind %0d: got %0d expected %0d", it, kind, lat, exp_lat); end
      checks++; if (nx != exp_nx) begin errors++; $display("FAIL rnd%0d_xfers kind %0d: got %0d expected %0d", it, kind, nx, exp_nx); end
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_addr_stable: got 0 expected 1", it); end
      if (kind == 0) begin
        m_last = hit ? m_data : model_word(a);
        checks++; if (rd !== m_last) begin errors++; $display("FAIL rnd%0d_fetch_data: got %h expected %h", it, rd, m_last); end
      end else if (kind == 1) begin
        exp_lo = '{we: 1'b1, addr: {a, 1'b0}, data: wd[31:0]};
        exp_hi = '{we: 1'b1, addr: {a, 1'b1}, data: {{15{TB_HI_PAD}}, wd[48:32]}};
        if (nx == 2) begin
          checks++; if (log_q[b] !== exp_lo || log_q[b+1] !== exp_hi) begin errors++; $display("FAIL rnd%0d_write_bus: got %h %h expected %h %h", it, log_q[b], log_q[b+1], exp_lo, exp_hi); end
        end
        model_write(a, wd);
      end else begin
        checks++; if (nr != 0 || rd !== m_last) begin errors++; $display("FAIL rnd%0d_prefetch_quiet: got ready %0d rdata %h expected 0 %h", it, nr, rd, m_last); end
        if (!hit) begin m_valid = 1'b1; m_tag = a; m_data = model_word(a); end
      end
    end
    ack_delay = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    ack_delay = 0; ack_limit = -1; inject_req = 0;
    bus.mcr_addr = '0; bus.mcr_wdata = '0;
    bus.mcr_write = 1'b0; bus.fetch = 1'b0; bus.prefetch = 1'b0;
    rst_n = 1'b0;
    for (int unsigned i = 0; i < 32768; i++) ref_mem[i] = init_word(i);
    m_valid = 1'b0; m_tag = '0; m_data = '0; m_last = '0;
    test_reset();
    test_fetch_miss();
    test_prefetch();
    test_write_coherent();
    test_priority();
    test_reset_midflight();
    test_wait_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
